// File: rtl/axi_lite_game_timer.sv
// AXI4-Lite timer peripheral: four registers drive a prescaled down-counter
// that raises a one-cycle tick and a level IRQ on each expiry.
module axi_lite_game_timer #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              tick_o,
    output logic                              irq_o
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = DW / 8;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_LOAD   = 2'd1;
    localparam logic [1:0] A_PRESC  = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} wstate_t;

    wstate_t         wstate_q, wstate_d;
    logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]      waddr_q, waddr_d;
    logic [DW-1:0]   wbuf_q, wbuf_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            aw_hs_c, w_hs_c, commit_c;
    logic [1:0]      cm_addr_c;
    logic [DW-1:0]   cm_data_c;
    logic [SW-1:0]   cm_strb_c;

    logic [2:0]      ctrl_q, ctrl_d;
    logic [DW-1:0]   load_q, load_d, presc_q, presc_d;
    logic [DW-1:0]   count_q, count_d, pcnt_q, pcnt_d;
    logic            expired_q, expired_d, tick_q, irq_q, irq_d;
    logic            step_c, expiry_c;

    logic            arready_q, arready_d, rvalid_q, rvalid_d, ar_hs_c;
    logic [DW-1:0]   rdata_q, rdata_d, rd_mux_c;

    logic            unused_sink;

    function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] new_v,
                                                 input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        for (int unsigned b = 0; b < SW; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    assign aw_hs_c = S_AXI_AWVALID & awready_q;
    assign w_hs_c  = S_AXI_WVALID & wready_q;
    assign ar_hs_c = S_AXI_ARVALID & arready_q;

    // Write channel: collect AW and W in either order, commit once both are in.
    always_comb begin
        wstate_d  = wstate_q;
        waddr_d   = waddr_q;
        wbuf_d    = wbuf_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        commit_c  = 1'b0;
        cm_addr_c = aw_hs_c ? S_AXI_AWADDR[3:2] : waddr_q;
        cm_data_c = w_hs_c ? S_AXI_WDATA : wbuf_q;
        cm_strb_c = w_hs_c ? S_AXI_WSTRB : wstrb_q;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs_c && w_hs_c) begin
                    commit_c  = 1'b1;
                    wstate_d  = W_RESP;
                end else if (aw_hs_c) begin
                    waddr_d   = S_AXI_AWADDR[3:2];
                    wstate_d  = W_WAIT_W;
                end else if (w_hs_c) begin
                    wbuf_d    = S_AXI_WDATA;
                    wstrb_d   = S_AXI_WSTRB;
                    wstate_d  = W_WAIT_AW;
                end
            end
            W_WAIT_W: begin
                if (w_hs_c) begin
                    commit_c = 1'b1;
                    wstate_d = W_RESP;
                end
            end
            W_WAIT_AW: begin
                if (aw_hs_c) begin
                    commit_c = 1'b1;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d = 1'b0;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
        if (commit_c) begin
            bvalid_d = 1'b1;
        end
        awready_d = (wstate_d == W_IDLE) || (wstate_d == W_WAIT_AW);
        wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_WAIT_W);
    end

    always_comb begin
        case (S_AXI_ARADDR[3:2])
            A_CTRL:   rd_mux_c = {{(DW-3){1'b0}}, ctrl_q};
            A_LOAD:   rd_mux_c = load_q;
            A_PRESC:  rd_mux_c = presc_q;
            default:  rd_mux_c = {count_q[DW-2:0], expired_q};
        endcase
    end

    // Counter and register update; software writes are applied after the
    // expiry effects so that a CTRL write overrides the auto-clear of EN.
    always_comb begin
        ctrl_d    = ctrl_q;
        load_d    = load_q;
        presc_d   = presc_q;
        count_d   = count_q;
        pcnt_d    = pcnt_q;
        expired_d = expired_q;
        step_c    = ctrl_q[0] && (pcnt_q == presc_q);
        expiry_c  = step_c && (count_q <= DW'(1));
        if (ctrl_q[0]) begin
            pcnt_d = step_c ? '0 : pcnt_q + DW'(1);
        end
        if (expiry_c) begin
            count_d   = ctrl_q[1] ? load_q : '0;
            ctrl_d[0] = ctrl_q[1];
        end else if (step_c) begin
            count_d = count_q - DW'(1);
        end
        if (commit_c) begin
            case (cm_addr_c)
                A_CTRL: begin
                    if (cm_strb_c[0]) begin
                        ctrl_d = cm_data_c[2:0];
                        if (cm_data_c[0] && !ctrl_q[0]) begin
                            count_d = load_q;
                            pcnt_d  = '0;
                        end
                    end
                end
                A_LOAD:   load_d  = byte_merge(load_q, cm_data_c, cm_strb_c);
                A_PRESC:  presc_d = byte_merge(presc_q, cm_data_c, cm_strb_c);
                default: begin
                    if (cm_strb_c[0] && cm_data_c[0]) begin
                        expired_d = 1'b0;
                    end
                end
            endcase
        end
        if (expiry_c) begin
            expired_d = 1'b1;
        end
        irq_d     = expired_d & ctrl_d[2];
        rvalid_d  = ar_hs_c | (rvalid_q & ~S_AXI_RREADY);
        rdata_d   = ar_hs_c ? rd_mux_c : rdata_q;
        arready_d = ~rvalid_d;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            waddr_q   <= '0;
            wbuf_q    <= '0;
            wstrb_q   <= '0;
            ctrl_q    <= '0;
            load_q    <= '0;
            presc_q   <= '0;
            count_q   <= '0;
            pcnt_q    <= '0;
            expired_q <= 1'b0;
            tick_q    <= 1'b0;
            irq_q     <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            waddr_q   <= waddr_d;
            wbuf_q    <= wbuf_d;
            wstrb_q   <= wstrb_d;
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            pcnt_q    <= pcnt_d;
            expired_q <= expired_d;
            tick_q    <= expiry_c;
            irq_q     <= irq_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign tick_o        = tick_q;
    assign irq_o         = irq_q;

    assign unused_sink = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: doc/axi_lite_game_timer.md
Name: axi_lite_game_timer

Overview:
AXI4-Lite slave timer peripheral, directly downstream of the AXI master (VIP in simulation, PS/MicroBlaze in system); consumes its AW/W/B/AR/R traffic. Four 32-bit registers configure a prescaled down-counter that drives game timing events (bomb fuses, round clock) as a one-cycle tick and a level IRQ. One outstanding transaction per channel; OKAY responses only.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; addr[3:2] selects register, addr[1:0] ignored.

Ports:
ACLK  in  1  single clock, rising edge.
ARESETN  in  1  asynchronous active-low reset.
S_AXI_AWADDR  in  4  write address.  S_AXI_AWPROT in 3, ignored.
S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1  write-address handshake.
S_AXI_WDATA  in  32  write data.  S_AXI_WSTRB in 4, byte enables.
S_AXI_WVALID in 1 / S_AXI_WREADY out 1  write-data handshake.
S_AXI_BRESP  out  2  always 2'b00.  S_AXI_BVALID out 1 / S_AXI_BREADY in 1.
S_AXI_ARADDR  in  4  read address.  S_AXI_ARPROT in 3, ignored.
S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1  read-address handshake.
S_AXI_RDATA  out  32.  S_AXI_RRESP out 2, always 2'b00.  S_AXI_RVALID out 1 / S_AXI_RREADY in 1.
tick_o  out  1  one-cycle pulse on each expiry.
irq_o  out  1  STATUS.EXPIRED & CTRL.IRQ_EN, registered.

Behaviour:
- Register map: 0x0 CTRL RW [0]EN [1]RELOAD [2]IRQ_EN, other bits read 0; 0x4 LOAD RW 32b; 0x8 PRESCALE RW 32b; 0xC STATUS: read {COUNT[30:0],EXPIRED}, write bit0=1 clears EXPIRED (W1C), other bits ignored.
- WSTRB applied per byte to CTRL/LOAD/PRESCALE; STATUS W1C only if WSTRB[0].
- Reset (async assert, sync release): all regs, COUNT, prescaler = 0; AWREADY=WREADY=ARREADY=0 during reset then 1 in idle; BVALID=RVALID=tick_o=irq_o=0; RDATA=0. Reset mid-transaction drops BVALID/RVALID immediately, transaction lost.
- Write FSM: W_IDLE (AWREADY=WREADY=1) -> both handshakes same cycle: commit -> W_RESP; AW only -> W_WAIT_W (WREADY=1, AWREADY=0); W only -> W_WAIT_AW (AWREADY=1, WREADY=0); WAIT_* -> missing handshake: commit -> W_RESP. Register updated at the commit edge; BVALID=1 the following cycle, held until BREADY, then W_IDLE. AW/W readys 0 in W_RESP.
- Read: ARREADY=1 when RVALID=0. On AR handshake RDATA latched (value at handshake edge), RVALID=1 next cycle, held stable until RREADY, ARREADY=0 meanwhile. Read and write channels independent.
- Counter: write setting CTRL.EN 0->1 loads COUNT<=LOAD, prescaler<=0. While EN: prescaler increments each cycle; at prescaler==PRESCALE it wraps to 0 (step). Step with COUNT<=1: expiry; else COUNT-1. Expiry: tick_o=1 next cycle, EXPIRED<=1, COUNT<=RELOAD?LOAD:0, EN<=RELOAD. Period = max(LOAD,1)*(PRESCALE+1) cycles.
- EN written 0: counter freezes, COUNT retained; re-enable reloads.
- Simultaneous: expiry set beats W1C clear same cycle (EXPIRED stays 1); software CTRL write beats expiry auto-clear of EN; LOAD write same cycle as reload: reload uses old LOAD.
- Arithmetic unsigned 32b; prescaler 32b, no overflow since compared for equality.

Test Plan:
- Reset: hold ARESETN=0 200 ns -> all outputs 0; after release AWREADY=WREADY=ARREADY=1; read 0x0..0xC -> 0.
- Write/readback: write 0x4=0x00000002, 0x8=0x00000003 with AW and W in same cycle, AW-first, W-first -> BRESP=00 each; reads return 2, 3; BVALID held 5 cycles with BREADY=0.
- One-shot: PRESCALE=0, LOAD=3, CTRL=0x1 -> tick_o single pulse 3 cycles after enable, STATUS=0x1, CTRL reads 0x0, no further ticks in 20 cycles.
- Auto-reload+IRQ: PRESCALE=1, LOAD=2, CTRL=0x7 -> tick_o every 4 cycles, irq_o=1 after first; W1C 0xC=1 between ticks -> irq_o=0, reasserts at next tick.
- Collision: W1C commit on expiry cycle -> EXPIRED remains 1; WSTRB=0x1 write 0xFFFFFFFF to LOAD=0 -> LOAD=0x000000FF.
- Reset mid-op: assert ARESETN while RVALID=1 and counter running -> RVALID, tick_o, irq_o to 0 at once; regs 0 after release.
